ds_cmd_sequencer: RTL and testbench

Parametrised successor to the fixed DS1302 command decoder. It drives the byte-level DS1302 function engine through a start/done handshake. After reset it runs an automatic init sequence: unprotect, preload the time registers, protect. It then serves single-register host reads and writes, wrapping host writes in unprotect/protect automatically. It also polls the lowest NUM_REGS clock registers periodically and publishes a shadow copy.

---
 rtl/ds1302_pkg.sv | 33 +++
 rtl/ds_func_issue.sv | 57 +++++
 rtl/ds_cmd_sequencer.sv | 238 +++++++++++++++++++++++
 tb/tb_ds_cmd_sequencer.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ds1302_pkg.sv
// Shared definitions for the DS1302 command sequencer and its function-engine
// issue helper: engine function codes, write-protect register constants,
// the burst index, sequencer states and the command-byte builder.
package ds1302_pkg;

  localparam logic [1:0] FUNC_WR   = 2'b10;
  localparam logic [1:0] FUNC_RD   = 2'b01;
  localparam logic [1:0] FUNC_IDLE = 2'b00;

  localparam logic [7:0] WP_ADDR = 8'h8E;
  localparam logic [7:0] WP_CLR  = 8'h00;
  localparam logic [7:0] WP_SET  = 8'h80;

  localparam logic [4:0] BURST_IDX = 5'd31;

  typedef enum logic [3:0] {
    S_INIT_UNP,
    S_INIT_REG,
    S_INIT_PROT,
    S_IDLE,
    S_HOST_UNP,
    S_HOST_OP,
    S_HOST_PROT,
    S_POLL,
    S_RESP
  } seq_state_t;

  // DS1302 command byte: {1, ram_sel, idx[4:0], rd}
  function automatic logic [7:0] mk_cmd(input logic ram, input logic [4:0] idx, input logic rd);
    return {1'b1, ram, idx, rd};
  endfunction

endpackage

// File: rtl/ds_func_issue.sv
// Start/done handshake towards the byte-level DS1302 function engine.
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   start, op, addr, wdata operation request from the sequencer (taken when ready)
//   ready                 no operation in flight
//   done                  one-cycle pulse the cycle after func_done; rdata valid
//   rdata                 byte captured on the func_done cycle
//   func_start, register_addr, write_data, func_done, read_data  engine side
// Because func_start drops on the func_done edge and done is reported a cycle
// later, the sequencer can never start the next operation back-to-back: at
// least one idle cycle always separates engine operations.
module ds_func_issue
  import ds1302_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [1:0] op,
  input  logic [7:0] addr,
  input  logic [7:0] wdata,
  output logic       ready,
  output logic       done,
  output logic [7:0] rdata,
  output logic [1:0] func_start,
  output logic [7:0] register_addr,
  output logic [7:0] write_data,
  input  logic       func_done,
  input  logic [7:0] read_data
);

  assign ready = (func_start == FUNC_IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      func_start    <= FUNC_IDLE;
      register_addr <= 8'h00;
      write_data    <= 8'h00;
      rdata         <= 8'h00;
      done          <= 1'b0;
    end else begin
      done <= 1'b0;
      if (func_start != FUNC_IDLE) begin
        // func_done outside an operation (e.g. stale after reset) is ignored
        if (func_done) begin
          func_start <= FUNC_IDLE;
          rdata      <= read_data;
          done       <= 1'b1;
        end
      end else if (start) begin
        func_start    <= op;
        register_addr <= addr;
        write_data    <= wdata;
      end
    end
  end

endmodule

// File: rtl/ds_cmd_sequencer.sv
// DS1302 command sequencer: runs the init sequence (unprotect, preload clock
// registers, protect), serves single-register host reads/writes (writes
// optionally wrapped in unprotect/protect), and periodically polls clock
// registers 0..NUM_REGS-1 into a shadow published on time_regs.
// Ports:
//   clk, rst_n                         clock, synchronous active-low reset
//   req_valid/ready/write/reg/data     host request
//   rsp_valid/data/err                 one-cycle host response
//   poll_en, time_regs, time_valid     periodic poll control and result
//   init_done                          init sequence finished (level)
//   func_start, func_done, register_addr, write_data, read_data  engine side
module ds_cmd_sequencer
  import ds1302_pkg::*;
#(
  parameter int                    NUM_REGS     = 3,
  parameter logic [8*NUM_REGS-1:0] INIT_DATA    = 24'h22_13_00,
  parameter int                    POLL_PERIOD  = 50_000_000,
  parameter bit                    WRAP_PROTECT = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [5:0]            req_reg,
  input  logic [7:0]            req_data,
  output logic                  rsp_valid,
  output logic [7:0]            rsp_data,
  output logic                  rsp_err,
  input  logic                  poll_en,
  output logic [8*NUM_REGS-1:0] time_regs,
  output logic                  time_valid,
  output logic                  init_done,
  output logic [1:0]            func_start,
  input  logic                  func_done,
  output logic [7:0]            register_addr,
  output logic [7:0]            write_data,
  input  logic [7:0]            read_data
);

  localparam int               CNT_W    = (POLL_PERIOD > 1) ? $clog2(POLL_PERIOD) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(POLL_PERIOD - 1);
  localparam logic [2:0]       IDX_LAST = 3'(NUM_REGS - 1);

  seq_state_t state, state_next;

  logic                     issued;
  logic [2:0]               idx;
  logic                     h_write, h_ram, h_wrap;
  logic [4:0]               h_idx;
  logic [7:0]               h_data;
  logic [7:0]               rsp_data_q;
  logic                     rsp_err_q;
  logic [NUM_REGS-1:0][7:0] shadow, time_q;
  logic [CNT_W-1:0]         poll_cnt;
  logic                     poll_pending;

  logic       iss_start, iss_ready, iss_done;
  logic [1:0] iss_op;
  logic [7:0] iss_addr, iss_wdata, iss_rdata, init_byte;
  logic       op_state, accept, poll_go, req_burst, req_wrap;

  assign req_burst = (req_reg[4:0] == BURST_IDX);
  // The write-protect register itself is written bare
  assign req_wrap  = WRAP_PROTECT && req_write && (req_reg != 6'd7);
  assign op_state  = (state != S_IDLE) && (state != S_RESP);
  assign iss_start = op_state && !issued;

  assign rsp_valid = (state == S_RESP);
  assign rsp_data  = rsp_valid ? rsp_data_q : 8'h00;
  assign rsp_err   = rsp_valid && rsp_err_q;
  assign time_regs = time_q;

  always_comb begin
    init_byte = 8'h00;
    for (int j = 0; j < NUM_REGS; j++)
      if (3'(j) == idx) init_byte = INIT_DATA[8*j +: 8];
  end

  always_comb begin
    state_next = state;
    iss_op     = FUNC_WR;
    iss_addr   = 8'h00;
    iss_wdata  = 8'h00;
    req_ready  = 1'b0;
    accept     = 1'b0;
    poll_go    = 1'b0;
    case (state)
      S_INIT_UNP: begin
        iss_addr  = WP_ADDR;
        iss_wdata = WP_CLR;
        if (iss_done) state_next = S_INIT_REG;
      end
      S_INIT_REG: begin
        iss_addr  = mk_cmd(1'b0, {2'b00, idx}, 1'b0);
        iss_wdata = init_byte;
        if (iss_done && idx == 3'd0) state_next = S_INIT_PROT;
      end
      S_INIT_PROT: begin
        iss_addr  = WP_ADDR;
        iss_wdata = WP_SET;
        if (iss_done) state_next = S_IDLE;
      end
      S_IDLE: begin
        req_ready = iss_ready;
        if (iss_ready) begin
          // host requests win over a pending poll round
          if (req_valid) begin
            accept = 1'b1;
            if (req_burst)     state_next = S_RESP;
            else if (req_wrap) state_next = S_HOST_UNP;
            else               state_next = S_HOST_OP;
          end else if (poll_pending) begin
            poll_go    = 1'b1;
            state_next = S_POLL;
          end
        end
      end
      S_HOST_UNP: begin
        iss_addr  = WP_ADDR;
        iss_wdata = WP_CLR;
        if (iss_done) state_next = S_HOST_OP;
      end
      S_HOST_OP: begin
        iss_op    = h_write ? FUNC_WR : FUNC_RD;
        iss_addr  = mk_cmd(h_ram, h_idx, ~h_write);
        iss_wdata = h_data;
        if (iss_done) state_next = h_wrap ? S_HOST_PROT : S_RESP;
      end
      S_HOST_PROT: begin
        iss_addr  = WP_ADDR;
        iss_wdata = WP_SET;
        if (iss_done) state_next = S_RESP;
      end
      S_POLL: begin
        iss_op   = FUNC_RD;
        iss_addr = mk_cmd(1'b0, {2'b00, idx}, 1'b1);
        if (iss_done && idx == IDX_LAST) state_next = S_IDLE;
      end
      S_RESP:  state_next = S_IDLE;
      default: state_next = S_INIT_UNP;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_INIT_UNP;
    else        state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      issued     <= 1'b0;
      idx        <= 3'd0;
      h_write    <= 1'b0;
      h_ram      <= 1'b0;
      h_idx      <= 5'd0;
      h_data     <= 8'h00;
      h_wrap     <= 1'b0;
      rsp_data_q <= 8'h00;
      rsp_err_q  <= 1'b0;
      shadow     <= '0;
      time_q     <= '0;
      time_valid <= 1'b0;
      init_done  <= 1'b0;
    end else begin
      time_valid <= 1'b0;
      // one engine operation per op-state visit
      if (iss_start && iss_ready) issued <= 1'b1;
      else if (iss_done)          issued <= 1'b0;
      if (accept) begin
        h_write    <= req_write;
        h_ram      <= req_reg[5];
        h_idx      <= req_reg[4:0];
        h_data     <= req_data;
        h_wrap     <= req_wrap;
        rsp_data_q <= 8'h00;
        rsp_err_q  <= req_burst;
      end
      if (poll_go) idx <= 3'd0;
      if (iss_done) begin
        case (state)
          S_INIT_UNP:  idx <= IDX_LAST;
          S_INIT_REG:  idx <= idx - 3'd1;
          S_INIT_PROT: init_done <= 1'b1;
          S_HOST_OP:   if (!h_write) rsp_data_q <= iss_rdata;
          S_POLL: begin
            for (int j = 0; j < NUM_REGS; j++)
              if (3'(j) == idx) shadow[j] <= iss_rdata;
            idx <= idx + 3'd1;
            // publish the whole round at once, including the byte just read
            if (idx == IDX_LAST) begin
              for (int j = 0; j < NUM_REGS; j++)
                time_q[j] <= (3'(j) == idx) ? iss_rdata : shadow[j];
              time_valid <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // A second expiry while a round is pending is simply absorbed.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      poll_cnt     <= '0;
      poll_pending <= 1'b0;
    end else begin
      if (poll_go) poll_pending <= 1'b0;
      if (!poll_en) begin
        poll_cnt <= '0;
      end else if (poll_cnt == CNT_LAST) begin
        poll_cnt     <= '0;
        poll_pending <= 1'b1;
      end else begin
        poll_cnt <= poll_cnt + 1'b1;
      end
    end
  end

  ds_func_issue u_issue (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (iss_start),
    .op           (iss_op),
    .addr         (iss_addr),
    .wdata        (iss_wdata),
    .ready        (iss_ready),
    .done         (iss_done),
    .rdata        (iss_rdata),
    .func_start   (func_start),
    .register_addr(register_addr),
    .write_data   (write_data),
    .func_done    (func_done),
    .read_data    (read_data)
  );

endmodule

// File: tb/tb_ds_cmd_sequencer.sv
// Bench for ds_cmd_sequencer: a DS1302 memory model behind the engine port
// (honouring write protect), a reference register map updated at request
// acceptance, and a scoreboard monitor checking every host response and
// every published poll round.
module tb_ds_cmd_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_write;
  logic [5:0]  req_reg;
  logic [7:0]  req_data;
  logic        rsp_valid, rsp_err;
  logic [7:0]  rsp_data;
  logic        poll_en;
  logic [23:0] time_regs;
  logic        time_valid, init_done;
  logic [1:0]  func_start;
  logic        func_done;
  logic [7:0]  register_addr, write_data, read_data;

  always #5 clk = ~clk;

  ds_cmd_sequencer #(
    .NUM_REGS(3), .INIT_DATA(24'h22_13_00), .POLL_PERIOD(16), .WRAP_PROTECT(1'b1)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_reg(req_reg), .req_data(req_data),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .poll_en(poll_en), .time_regs(time_regs), .time_valid(time_valid),
    .init_done(init_done),
    .func_start(func_start), .func_done(func_done),
    .register_addr(register_addr), .write_data(write_data), .read_data(read_data)
  );

  typedef struct {
    logic [7:0] data;
    logic       err;
    int         ops;
    int         cyc;
  } exp_t;

  int          n_cmp = 0, n_fail = 0;
  int          cyc = 0, eng_ops = 0, tv_count = 0;
  logic [7:0]  engmem [64];
  logic [7:0]  refmem [64];
  logic [15:0] elog[$];
  logic [15:0] want[$];
  exp_t        sb[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: timed out", name);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // DS1302 engine model: random latency, write protect honoured, reset abandons
  logic       eng_busy = 1'b0, e_wr = 1'b0;
  int         eng_wait = 0;
  logic [7:0] e_cmd = 8'h00, e_data = 8'h00;
  initial begin
    func_done = 1'b0;
    read_data = 8'h00;
    forever begin
      @(posedge clk); #1;
      func_done = 1'b0;
      if (rst_n !== 1'b1) begin
        eng_busy = 1'b0;
      end else if (eng_busy) begin
        if (eng_wait == 0) begin
          if (e_wr) begin
            if (e_cmd == 8'h8E || !engmem[7][7]) engmem[e_cmd[6:1]] = e_data;
            elog.push_back({e_cmd, e_data});
          end else begin
            read_data = engmem[e_cmd[6:1]];
            elog.push_back({e_cmd, read_data});
          end
          func_done = 1'b1;
          eng_busy  = 1'b0;
        end else begin
          eng_wait--;
        end
      end else if (func_start != 2'b00) begin
        eng_busy = 1'b1;
        eng_wait = int'($urandom_range(0, 4));
        e_cmd    = register_addr;
        e_data   = write_data;
        e_wr     = (func_start == 2'b10);
        eng_ops++;
        chk("cmd_rd_bit", {30'd0, e_cmd[7], e_cmd[0]}, {30'd0, 1'b1, ~e_wr});
      end
    end
  end

  // Scoreboard monitor
  logic [1:0] prev_fs = 2'b00;
  logic [7:0] prev_addr = 8'h00, prev_wd = 8'h00;
  logic       prev_done = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (rsp_valid === 1'b1) begin
      if (sb.size() == 0) begin
        timeout("rsp_unexpected");
      end else begin
        e = sb.pop_front();
        chk("rsp_data_err", {23'd0, rsp_err, rsp_data}, {23'd0, e.err, e.data});
        if (e.err) begin
          chk("err_no_engine_op", eng_ops, e.ops);
          chk("err_rsp_latency", cyc, e.cyc + 1);
        end
      end
    end
    if (time_valid === 1'b1) begin
      tv_count++;
      chk("time_regs", {8'h00, time_regs}, {8'h00, refmem[2], refmem[1], refmem[0]});
    end
    if (req_valid && req_ready === 1'b1) begin
      e.ops = eng_ops;
      e.cyc = cyc;
      e.err = 1'b0;
      e.data = 8'h00;
      if (req_reg[4:0] == 5'd31) begin
        e.err = 1'b1;
      end else if (req_write) begin
        refmem[req_reg] = req_data;
        if (req_reg != 6'd7) refmem[7] = 8'h80;
      end else begin
        e.data = refmem[req_reg];
      end
      sb.push_back(e);
    end
    if (rst_n === 1'b1) begin
      if (prev_done) chk("gap_after_done", {30'd0, func_start}, 32'd0);
      else if (func_start != 2'b00 && prev_fs != 2'b00)
        chk("op_stable", {16'd0, register_addr, write_data}, {16'd0, prev_addr, prev_wd});
    end
    prev_fs   = func_start;
    prev_addr = register_addr;
    prev_wd   = write_data;
    prev_done = func_done;
  end

  task automatic do_req(input logic w, input logic [5:0] r, input logic [7:0] d);
    int n = 0;
    @(posedge clk); #1;
    req_valid = 1'b1; req_write = w; req_reg = r; req_data = d;
    while (1) begin
      @(negedge clk);
      if (req_ready) break;
      n++;
      if (n > 5000) begin timeout("req_accept"); break; end
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_sb();
    int n = 0;
    while (sb.size() != 0 && n < 3000) begin @(negedge clk); n++; end
    if (sb.size() != 0) timeout("rsp_wait");
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_init();
    int n = 0;
    while (!init_done && n < 3000) begin @(negedge clk); n++; end
    chk("init_done", {31'd0, init_done}, 32'd1);
  endtask

  task automatic check_log(input string name);
    chk({name, "_len"}, elog.size(), want.size());
    for (int i = 0; i < want.size() && i < elog.size(); i++) chk(name, {16'd0, elog[i]}, {16'd0, want[i]});
  endtask

  task automatic set_init_want();
    want = '{16'h8E00, 16'h8422, 16'h8213, 16'h8000, 16'h8E80};
  endtask

  task automatic chk_reset_outputs(input string name);
    chk({name, "_eng"}, {14'd0, func_start, register_addr, write_data}, 32'd0);
    chk({name, "_ctl"}, {27'd0, req_ready, rsp_valid, rsp_err, time_valid, init_done}, 32'd0);
    chk({name, "_data"}, {rsp_data, time_regs}, 32'd0);
  endtask

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_reg = 6'd0; req_data = 8'h00; poll_en = 1'b0;
    for (int i = 0; i < 64; i++) engmem[i] = 8'($urandom);
    engmem[7] = 8'h80;
    refmem = engmem;
    refmem[0] = 8'h00; refmem[1] = 8'h13; refmem[2] = 8'h22; refmem[7] = 8'h80;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_outputs("reset");

    // init sequence
    @(posedge clk); #1 rst_n = 1'b1;
    wait_init();
    set_init_want();
    check_log("init_seq");

    // wrapped host write
    elog.delete();
    do_req(1'b1, 6'd2, 8'h09);
    wait_sb();
    want = '{16'h8E00, 16'h8409, 16'h8E80};
    check_log("host_wr_seq");

    // host read
    engmem[1] = 8'h45; refmem[1] = 8'h45;
    elog.delete();
    do_req(1'b0, 6'd1, 8'h00);
    wait_sb();
    want = '{16'h8345};
    check_log("host_rd_seq");

    // burst index rejected
    do_req(1'b1, 6'd31, 8'hAA);
    wait_sb();

    // directed poll round
    engmem[0] = 8'h12; engmem[1] = 8'h34; engmem[2] = 8'h56;
    refmem[0] = 8'h12; refmem[1] = 8'h34; refmem[2] = 8'h56;
    poll_en = 1'b1;
    n = 0;
    while (!time_valid && n < 500) begin @(negedge clk); n++; end
    if (!time_valid) timeout("poll_round");
    else chk("poll_directed", {8'h00, time_regs}, 32'h0056_3412);

    // randomized traffic with polls interleaved
    for (int i = 0; i < 150; i++) begin
      logic [5:0] r;
      r = 6'($urandom);
      if ($urandom_range(0, 7) == 0) r[4:0] = 5'd31;
      if ($urandom_range(0, 9) == 0) poll_en = ~poll_en;
      do_req(1'($urandom), r, 8'($urandom));
      repeat ($urandom_range(0, 15)) @(posedge clk);
    end
    wait_sb();
    poll_en = 1'b0;
    repeat (60) @(negedge clk);
    chk("poll_rounds_seen", {31'd0, tv_count >= 3}, 32'd1);

    // reset in the middle of a host write
    do_req(1'b1, 6'd3, 8'h5A);
    n = 0;
    while (!(func_start == 2'b10 && register_addr == 8'h86) && n < 500) begin @(negedge clk); n++; end
    if (n >= 500) timeout("mid_op_wait");
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1;
    sb.delete();
    elog.delete();
    @(negedge clk);
    chk_reset_outputs("mid_op_reset");
    @(posedge clk); #1 rst_n = 1'b1;
    wait_init();
    set_init_want();
    check_log("reinit_seq");
    refmem = engmem;
    do_req(1'b0, 6'd2, 8'h00);
    do_req(1'b0, 6'd0, 8'h00);
    wait_sb();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
